// File: rtl/ram_arb_pkg.sv
// Shared definitions for the structure-RAM port arbiter: RAM word geometry,
// arbiter state encoding and a ceiling-log2 helper for sizing counters.
package ram_arb_pkg;

  localparam int unsigned RAM_DATA_WIDTH = 64;
  localparam int unsigned RAM_BE_WIDTH   = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so that a field always has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: scans the request vector starting at ptr_i and
// returns the first set request as a one-hot grant plus its index.
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Rotated priority search; the first hit at or after ptr_i wins.
  always_comb begin
    int unsigned j;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr_i) + off) % N;
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
        found    = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one port of the 64-bit byte-enabled structure
// RAM among NUM_REQ requesters. Single-word read/write requests use a
// valid/ready handshake; responses return one cycle later with a one-hot
// valid and the RAM's registered output. A requester may lock the port for
// up to MAX_LOCK consecutive grants.
// Optional build macro RAM_ARB_PRIO_EN: requester 0 becomes fixed-highest
// priority while arbitrating (it never pre-empts a locked owner).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_LOCK   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*RAM_BE_WIDTH-1:0]  req_be,
  input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [RAM_DATA_WIDTH-1:0]        resp_rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic                             ram_we,
  output logic [RAM_BE_WIDTH-1:0]          ram_be,
  output logic [RAM_DATA_WIDTH-1:0]        ram_din,
  input  logic [RAM_DATA_WIDTH-1:0]        ram_dout
);

  localparam int unsigned IW = clog2(NUM_REQ);
  localparam int unsigned CW = clog2(MAX_LOCK + 1);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  resp_valid_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [IW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [CW-1:0]       cnt_inc;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Grant selection: round-robin (optionally requester-0 first) while
  // arbitrating, owner-only while locked.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    case (state_q)
      ARB: begin
`ifdef RAM_ARB_PRIO_EN
        if (req_valid[0]) begin
          gnt_oh[0] = 1'b1;
          gnt_idx   = '0;
          gnt_any   = 1'b1;
        end else begin
          gnt_oh  = pick_gnt;
          gnt_idx = pick_idx;
          gnt_any = pick_any;
        end
`else
        gnt_oh  = pick_gnt;
        gnt_idx = pick_idx;
        gnt_any = pick_any;
`endif
      end
      LOCKED: begin
        if (req_valid[owner_q]) begin
          gnt_oh[owner_q] = 1'b1;
          gnt_idx         = owner_q;
          gnt_any         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic: lock entry/exit, pointer advance and lock counting.
  // An exit decided this cycle still lets the owner's current transfer
  // through; the new state only governs the following cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CW'(MAX_LOCK)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      ARB: begin
        if (gnt_any) begin
          if (req_lock[gnt_idx] && (MAX_LOCK > 1)) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
            cnt_d   = CW'(1);
          end
`ifdef RAM_ARB_PRIO_EN
          else if (gnt_idx != '0) begin
            ptr_d = next_idx(gnt_idx);
          end
`else
          else begin
            ptr_d = next_idx(gnt_idx);
          end
`endif
        end
      end
      LOCKED: begin
        if (!req_valid[owner_q] || !req_lock[owner_q] ||
            (cnt_inc == CW'(MAX_LOCK))) begin
          state_d = ARB;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // Arbiter state and registered one-hot response valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= gnt_oh;
    end
  end

  assign req_ready  = gnt_oh;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = ram_dout;

  // With no grant gnt_idx is 0, so address/data idle at requester 0.
  assign ram_addr = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_din  = req_wdata[gnt_idx*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
  assign ram_we   = gnt_any & req_we[gnt_idx];
  assign ram_be   = gnt_any ? req_be[gnt_idx*RAM_BE_WIDTH +: RAM_BE_WIDTH] : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios followed by
// randomized traffic, compared against a behavioural arbiter/RAM model.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int ML = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      req_lock = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*8-1:0]    req_be = '0;
  logic [N*64-1:0]   req_wdata = '0;
  logic [N-1:0]      resp_valid;
  logic [63:0]       resp_rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [7:0]        ram_be;
  logic [63:0]       ram_din;
  logic [63:0]       ram_dout;

  ram_port_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .MAX_LOCK   (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lock   (req_lock),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_be     (ram_be),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // ---------------- RAM port (registered output, write-through) ----------
  logic [63:0] mem    [1024];
  bit          mem_wr [1024];

  function automatic logic [63:0] init_word(input int unsigned a);
    if (a == 5) return 64'h0123456789ABCDEF;
    if (a == 3) return 64'h0;
    return 64'hA5A5_0000_0000_0000 ^ (64'(a) * 64'h0001_0003_0007_000B);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = din[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ram_rd(input logic [AW-1:0] a);
    return mem_wr[a] ? mem[a] : init_word(32'(a));
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]    <= merge(ram_rd(ram_addr), ram_din, ram_be);
      mem_wr[ram_addr] <= 1'b1;
      ram_dout         <= merge(ram_rd(ram_addr), ram_din, ram_be);
    end else begin
      ram_dout <= ram_rd(ram_addr);
    end
  end

  // ---------------- checking ---------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus state ---------------------------------------
  bit          v  [N];
  bit          w  [N];
  bit          lk [N];
  logic [AW-1:0] ad [N];
  logic [7:0]  bs [N];
  logic [63:0] wd [N];

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      v[i] = 0; w[i] = 0; lk[i] = 0; ad[i] = '0; bs[i] = '0; wd[i] = '0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_lock[i]           = lk[i];
      req_we[i]             = w[i];
      req_addr[i*AW +: AW]  = ad[i];
      req_be[i*8 +: 8]      = bs[i];
      req_wdata[i*64 +: 64] = wd[i];
    end
  endtask

  // ---------------- reference model --------------------------------------
  int          m_ptr = 0;
  int          m_owner = 0;
  int          m_cnt = 0;
  bit          m_locked = 0;
  logic [N-1:0] exp_rv = '0;
  logic [63:0] exp_data = '0;
  logic [63:0] ref_mem [1024];
  bit          ref_wr  [1024];
  int          last_g = -1;

  function automatic logic [63:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(32'(a));
  endfunction

  function automatic int model_pick();
    if (m_locked) return v[m_owner] ? m_owner : -1;
`ifdef RAM_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; exp_rv = '0; last_g = -1;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    logic [63:0]  old;
    @(negedge clk);
    apply();
    #1;
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv != '0) check("resp_rdata", resp_rdata, exp_data);
    g = model_pick();
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      check("ram_addr", 64'(ram_addr), 64'(ad[g]));
      check("ram_we", 64'(ram_we), 64'(w[g]));
      check("ram_be", 64'(ram_be), 64'(bs[g]));
      if (w[g]) check("ram_din", ram_din, wd[g]);
      old = ref_rd(ad[g]);
      if (w[g]) begin
        exp_data        = merge(old, wd[g], bs[g]);
        ref_mem[ad[g]]  = exp_data;
        ref_wr[ad[g]]   = 1'b1;
      end else begin
        exp_data = old;
      end
    end else begin
      check("ram_we_idle", 64'(ram_we), 64'(0));
      check("ram_be_idle", 64'(ram_be), 64'(0));
    end
    exp_rv = exp_rdy;
    // Arbitration rules applied at the clock edge.
    if (m_locked) begin
      if (!v[m_owner] || !lk[m_owner]) begin
        m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
      end else begin
        m_cnt++;
        if (m_cnt >= ML) begin
          m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end
      end
    end else if (g >= 0) begin
      if (lk[g] && ML > 1) begin
        m_locked = 1; m_owner = g; m_cnt = 1;
      end else begin
`ifdef RAM_ARB_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end
    end
    last_g = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_stim();
    apply();
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------------------------------
  initial begin
    int run;
    bit done;
    logic [N-1:0] first_other;
    logic [N-1:0] exp_oh;

    clear_stim();
    apply();
    do_reset();

    // Lone read from requester 2 of a known word.
    v[2] = 1; w[2] = 0; ad[2] = 10'd5; bs[2] = 8'hFF;
    cycle();
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    v[2] = 0;
    cycle();
    check("single_resp_valid", 64'(resp_valid), 64'(4'b0100));
    check("single_resp_data", resp_rdata, 64'h0123456789ABCDEF);

    // All four continuously valid: one grant per cycle in rotation.
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1; w[i] = 0; ad[i] = AW'(10 + i); bs[i] = 8'hFF;
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_oh = N'(1 << (k % N));
`ifdef RAM_ARB_PRIO_EN
      exp_oh = N'(1);
`endif
      check("rr_order", 64'(req_ready), 64'(exp_oh));
    end
    clear_stim();
    cycle();

    // Partial write then read-back.
    v[1] = 1; w[1] = 1; ad[1] = 10'd3; bs[1] = 8'h0F; wd[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    w[1] = 0;
    cycle();
    check("write_resp", resp_rdata, 64'h00000000FFFFFFFF);
    v[1] = 0;
    cycle();
    check("readback", resp_rdata, 64'h00000000FFFFFFFF);

    // Locked burst by requester 3 while requester 0 waits.
    v[3] = 1; lk[3] = 1; w[3] = 0; ad[3] = 10'd9; bs[3] = 8'hFF;
    v[0] = 1; w[0] = 0; ad[0] = 10'd2; bs[0] = 8'hFF;
    run = 0; done = 0; first_other = '0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (!done && req_ready == 4'b1000) run++;
      else if (!done) begin
        done = 1; first_other = req_ready;
      end
    end
`ifndef RAM_ARB_PRIO_EN
    check("lock_run", 64'(run), 64'(ML));
    check("lock_next", 64'(first_other), 64'(4'b0001));
`endif
    clear_stim();
    cycle();

    // Reset in the cycle after a read grant drops the pending response.
    v[1] = 1; w[1] = 0; ad[1] = 10'd7; bs[1] = 8'hFF;
    cycle();
    do_reset();
    v[1] = 1; ad[1] = 10'd7; bs[1] = 8'hFF;
    v[3] = 1; ad[3] = 10'd8; bs[3] = 8'hFF;
    cycle();
    check("post_rst_grant", 64'(req_ready), 64'(4'b0010));
    clear_stim();
    cycle();

    // Requesters 0 and 2 continuously valid.
    do_reset();
    v[0] = 1; ad[0] = 10'd1; bs[0] = 8'hFF;
    v[2] = 1; ad[2] = 10'd4; bs[2] = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      cycle();
      exp_oh = (k % 2 == 1) ? N'(4'b0100) : N'(4'b0001);
`ifdef RAM_ARB_PRIO_EN
      exp_oh = N'(4'b0001);
`endif
      check("prio_pattern", 64'(req_ready), 64'(exp_oh));
    end
    clear_stim();
    cycle();

    // Randomized traffic; a pending request holds until it is granted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_g == i || !v[i]) begin
          v[i]  = ($urandom_range(0, 3) != 0);
          w[i]  = $urandom_range(0, 1) == 1;
          lk[i] = ($urandom_range(0, 3) == 0);
          ad[i] = AW'($urandom_range(0, 15));
          bs[i] = 8'($urandom);
          wd[i] = {$urandom, $urandom};
        end
      end
      cycle();
    end
    clear_stim();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the 64-bit byte-enabled dual-port structure RAM among NUM_REQ requesters (pixel writers, palette/readback engines). Each requester issues single-word read or write requests over a valid/ready handshake. Responses return one cycle later on a shared data bus with a one-hot valid. An optional lock lets a requester hold the port for a bounded burst.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 10, RAM word address width
- MAX_LOCK, 16, maximum consecutive grants to one locked requester (≥1)

Ports:
- clk  in  1  single clock; RAM is clocked by the same clk
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  grant; a transfer occurs when valid&ready
- req_lock  in  NUM_REQ  requester asks to keep the grant next cycle
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed word addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_be  in  NUM_REQ*8  packed byte enables
- req_wdata  in  NUM_REQ*64  packed write data
- resp_valid  out  NUM_REQ  one-hot; response for the request accepted in the previous cycle
- resp_rdata  out  64  RAM port output (read data, or write-through data for writes)
- ram_addr  out  ADDR_WIDTH  to RAM port address
- ram_we  out  1  to RAM port write enable
- ram_be  out  8  to RAM port byte enables
- ram_din  out  64  to RAM port write data
- ram_dout  in  64  from RAM port registered data out

## Operation
- At most one grant per cycle. req_ready is combinational from req_valid, the pointer, and the lock state. It is never asserted to a requester whose valid is low.
- RAM drive: ram_addr/ram_be/ram_din are muxed from the granted requester. ram_we = req_we of the granted requester. With no grant, ram_we=0, ram_be=0, and addr/din are don't-care (held at requester 0 values).
- Round-robin: search starts at ptr. After a grant to requester g, ptr ← (g+1) mod NUM_REQ, unless the arbiter enters or stays LOCKED.
- FSM:
  - ARB: normal round-robin. If a grant to g happens with req_lock[g]=1, go to LOCKED(owner=g) with lock_cnt=1.
  - LOCKED: only the owner may be granted. Other requesters see ready=0 even when the owner is idle.
  - Each owner transfer with lock still high increments lock_cnt.
  - Exit to ARB when the owner drops req_lock, or drops req_valid, or lock_cnt reaches MAX_LOCK on a transfer. On exit, ptr ← owner+1.
- lock_cnt width is clog2(MAX_LOCK+1). It saturates and never wraps.
- Response: resp_valid ← one-hot of the granted requester, registered. resp_rdata = ram_dout, a direct wire. Write responses carry the written bytes per the RAM write-through; bytes with be=0 read old contents.
- Requesters must hold their req_* fields stable while valid&!ready.

## Timing
- Request accepted in cycle T → RAM sampled at edge ending T → resp_valid and resp_rdata valid in cycle T+1. Latency is 1 cycle.
- Throughput is 1 transfer/cycle, including back-to-back transfers from different requesters.
- Reset values: ptr=0, state=ARB, lock_cnt=0, resp_valid=0. req_ready is combinational; the first grant after reset goes to the lowest index valid requester.
- Reset asserted mid-operation: resp_valid clears immediately (asynchronously). Any in-flight response is dropped. A write sampled by the RAM before reset stays committed.
- Simultaneous events: a lock exit and a new request in the same cycle are handled as follows. The exit takes effect for the next cycle, and the grant in the current cycle still goes to the owner.
- The other RAM port is outside this block. Same-address conflicts between the two ports are the system's responsibility.

## Configuration
- RAM_ARB_PRIO_EN defined: requester 0 is fixed-highest priority in ARB state. It wins whenever valid, and ptr is not updated by its grants. It does not pre-empt an active LOCKED owner.
- RAM_ARB_PRIO_EN undefined: pure round-robin across all requesters.

## Structure
- Package ram_arb_pkg: RAM_DATA_WIDTH=64, RAM_BE_WIDTH=8, state enum {ARB, LOCKED}, clog2 helper function.
- Sub-module rr_picker: combinational rotate/priority-encode (inputs req vector and ptr; outputs one-hot grant and index). It is instantiated once in ram_port_arbiter.

## Test plan
- Reset, then requester 2 alone reads addr 5, where the init value is 0x0123456789ABCDEF → ready[2] in T, resp_valid=4'b0100 and resp_rdata=0x0123456789ABCDEF in T+1.
- All four requesters hold valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3 with one transfer per cycle.
- Requester 1 writes 0xFFFFFFFFFFFFFFFF to addr 3 with be=8'h0F, then reads addr 3 (addr 3 initialised to 0) → read returns 0x00000000FFFFFFFF.
- Requester 3 locks with MAX_LOCK=16 while requester 0 is valid → 16 consecutive grants to 3, then requester 0 is granted.
- Assert rst in the cycle after a read grant → resp_valid=0 immediately. After release, ptr=0 and the lowest valid requester is granted first.
- With RAM_ARB_PRIO_EN, requesters 0 and 2 both continuously valid → requester 0 is granted every cycle. Without the macro, grants alternate 0,2.
